// File: rtl/ftdi_link_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : ftdi_link_scheduler                                          |
// | Description : Time-shares the FTDI async-FIFO bus between host reads and   |
// |               host writes, schedules 1 KiB TX loads and handles flushes.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module ftdi_link_scheduler #(
  parameter int          BURST_MAX   = 64,
  parameter logic [16:0] RD_HIGH     = 17'd126976,
  parameter logic [15:0] GAP_MAX     = 16'd256,
  parameter logic [15:0] STALL_MAX   = 16'd50000,
  parameter logic [11:0] LOAD_CYCLES = 12'd2100,
  parameter logic [17:0] TX_CAP      = 18'd131072,
  parameter int          GUARD       = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush_req,
  input  logic        pkt_commit,
  input  logic        ftdi_rd,
  input  logic        ftdi_wr,
  input  logic        rdq_full,
  input  logic [16:0] rd_qsize,
  output logic        rd_en,
  output logic        wr_en,
  output logic        load_1k,
  output logic        clear,
  output logic [17:0] tx_pending,
  output logic        busy,
  output logic        stall,
  output logic        overflow
);

  localparam logic [7:0]  c_BURST      = BURST_MAX[7:0];
  localparam logic [3:0]  c_GUARD      = GUARD[3:0];
  localparam logic [17:0] c_LOAD_LIMIT = TX_CAP - 18'd1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT_RD = 3'd1,
    GRANT_WR = 3'd2,
    SWITCH   = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_rd;
  logic        r_rd_d;
  logic        r_wr_d;
  logic [7:0]  r_burst_ct;
  logic [15:0] r_gap_ct;
  logic [3:0]  r_guard_ct;
  logic [15:0] r_stall_ct;
  logic [11:0] r_timer;
  logic [17:0] r_tx;
  logic        r_pkt_pending;

  logic        w_rd_edge;
  logic        w_wr_edge;
  logic        w_own_edge;
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic        w_stall_hit;
  logic        w_zap;
  logic        w_load;
  logic        w_enter_grant;
  logic [17:0] w_tx_up;
  logic [17:0] w_tx_next;

  assign tx_pending = r_tx;
  assign busy       = (r_state != IDLE) || (r_timer != 12'd0);

  always_comb begin
    w_rd_edge   = ftdi_rd & ~r_rd_d;
    w_wr_edge   = ftdi_wr & ~r_wr_d;
    w_own_edge  = (r_state == GRANT_RD) ? w_rd_edge : w_wr_edge;
    w_rd_ok     = !rdq_full && (rd_qsize < RD_HIGH);
    w_stall_hit = (r_stall_ct == STALL_MAX);
    // A stalled link is not re-offered the write side until a flush clears it.
    w_wr_ok     = (r_tx != 18'd0) && !stall;

    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (enable) begin
          if (w_rd_ok && w_wr_ok) w_next = r_last_rd ? GRANT_WR : GRANT_RD;
          else if (w_rd_ok)       w_next = GRANT_RD;
          else if (w_wr_ok)       w_next = GRANT_WR;
        end
      end
      GRANT_RD: begin
        if (r_burst_ct == c_BURST || r_gap_ct == GAP_MAX || !enable || !w_rd_ok)
          w_next = SWITCH;
      end
      GRANT_WR: begin
        if (r_burst_ct == c_BURST || r_gap_ct == GAP_MAX || !enable || !w_wr_ok ||
            w_stall_hit)
          w_next = SWITCH;
      end
      SWITCH:  if (r_guard_ct == c_GUARD) w_next = IDLE;
      FLUSH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush_req) w_next = FLUSH;

    w_enter_grant = (w_next != r_state) && (w_next == GRANT_RD || w_next == GRANT_WR);
    w_zap     = (w_next == FLUSH) || (r_state == FLUSH);
    w_load    = !w_zap && r_pkt_pending && (r_timer == 12'd0) && (r_tx <= c_LOAD_LIMIT);
    w_tx_up   = w_load ? (r_tx + 18'd1024) : r_tx;
    w_tx_next = (w_wr_edge && w_tx_up != 18'd0) ? (w_tx_up - 18'd1) : w_tx_up;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_rd     <= 1'b0;
      r_rd_d        <= 1'b1;
      r_wr_d        <= 1'b1;
      r_burst_ct    <= 8'd0;
      r_gap_ct      <= 16'd0;
      r_guard_ct    <= 4'd0;
      r_stall_ct    <= 16'd0;
      r_timer       <= 12'd0;
      r_tx          <= 18'd0;
      r_pkt_pending <= 1'b0;
      rd_en         <= 1'b0;
      wr_en         <= 1'b0;
      load_1k       <= 1'b0;
      clear         <= 1'b0;
      stall         <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      r_rd_d  <= ftdi_rd;
      r_wr_d  <= ftdi_wr;
      r_state <= w_next;
      rd_en   <= (w_next == GRANT_RD);
      wr_en   <= (w_next == GRANT_WR);
      clear   <= (w_next == FLUSH);
      load_1k <= w_load;

      if (w_enter_grant) begin
        r_burst_ct <= 8'd0;
        r_gap_ct   <= 16'd0;
        r_last_rd  <= (w_next == GRANT_RD);
      end else if (r_state == GRANT_RD || r_state == GRANT_WR) begin
        if (w_own_edge) begin
          r_burst_ct <= r_burst_ct + 8'd1;
          r_gap_ct   <= 16'd0;
        end else begin
          r_gap_ct   <= r_gap_ct + 16'd1;
        end
      end

      // Guard only accumulates while both strobes rest high inside SWITCH.
      if (r_state != SWITCH)         r_guard_ct <= 4'd0;
      else if (ftdi_rd && ftdi_wr)   r_guard_ct <= r_guard_ct + 4'd1;
      else                           r_guard_ct <= 4'd0;

      if (w_zap) begin
        r_tx          <= 18'd0;
        r_pkt_pending <= 1'b0;
        r_timer       <= 12'd0;
        r_stall_ct    <= 16'd0;
        stall         <= 1'b0;
        overflow      <= 1'b0;
      end else begin
        r_tx <= w_tx_next;

        if (w_load)                  r_timer <= LOAD_CYCLES;
        else if (r_timer != 12'd0)   r_timer <= r_timer - 12'd1;

        if (pkt_commit)              r_pkt_pending <= 1'b1;
        else if (w_load)             r_pkt_pending <= 1'b0;

        if (pkt_commit && r_pkt_pending && !w_load) overflow <= 1'b1;

        if (r_tx == 18'd0 || w_wr_edge) r_stall_ct <= 16'd0;
        else if (!w_stall_hit)          r_stall_ct <= r_stall_ct + 16'd1;

        if (w_stall_hit) stall <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
